// File: rtl/red_pitaya_sort_pulser.sv
// Sort-trigger consumer: timestamps detector edges, queues their due times and
// fires a gate with a signed amplitude once each droplet reaches the junction.
module red_pitaya_sort_pulser #(
  parameter int QSZ = 3,
  parameter int MEM = 32,
  parameter int OWT = 14
) (
  input  logic            adc_clk_i,
  input  logic            adc_rst_i,
  input  logic            sort_trig_i,
  output logic            gate_o,
  output logic [OWT-1:0]  dac_o,
  output logic            busy_o,
  input  logic [31:0]     sys_addr,
  input  logic [31:0]     sys_wdata,
  input  logic [3:0]      sys_sel,
  input  logic            sys_wen,
  input  logic            sys_ren,
  output logic [31:0]     sys_rdata,
  output logic            sys_err,
  output logic            sys_ack
);

  localparam int DEPTH = 1 << QSZ;
  localparam logic [QSZ:0] FULL_LVL = {1'b1, {QSZ{1'b0}}};

  typedef enum logic {S_IDLE = 1'b0, S_PULSE = 1'b1} state_t;

  logic [MEM-1:0] ts_q, stamp_q, delay_q, width_q, fired_q, dropped_q;
  logic [OWT-1:0] amp_q;
  logic           trig_q, edge_q, en_q, ack_q;
  logic [31:0]    rdata_q;
  logic [MEM-1:0] q_mem [DEPTH];
  logic [QSZ-1:0] wr_ptr_q, rd_ptr_q;
  logic [QSZ:0]   level_q;

  state_t         state_q, state_d;
  logic [MEM-1:0] cnt_q, cnt_d;
  logic           gate_q, gate_d, busy_q, busy_d;
  logic [OWT-1:0] dac_q, dac_d;

  logic           wr_ctrl_s, clr_s, en_d, abort_s;
  logic           pop_s, full_s, push_req_s, push_s, drop_s;
  logic [MEM-1:0] head_s, age_s, load_s, fired_d, dropped_d;
  logic [QSZ-1:0] wr_ptr_d, rd_ptr_d;
  logic [QSZ:0]   level_d;
  logic [31:0]    rd_s;

  logic unused_s;
  assign unused_s = &{1'b0, sys_sel, sys_addr[31:20], sys_wdata};

  // Control decode, queue bookkeeping, FSM next state and read mux.
  always_comb begin
    wr_ctrl_s  = sys_wen && (sys_addr[19:0] == 20'h0000C);
    clr_s      = wr_ctrl_s && sys_wdata[1];
    en_d       = wr_ctrl_s ? sys_wdata[0] : en_q;
    abort_s    = !en_d || clr_s;

    // The compare timebase trails the stamp by the two capture stages, so a
    // droplet stamped at cycle N gates at N+DELAY+2; the sign bit keeps it wrap-safe.
    head_s     = q_mem[rd_ptr_q];
    age_s      = ts_q - MEM'(2) - head_s;
    pop_s      = (level_q != '0) && !age_s[MEM-1] && !abort_s;
    full_s     = (level_q == FULL_LVL);
    push_req_s = edge_q && en_q && !abort_s;
    push_s     = push_req_s && (!full_s || pop_s);
    drop_s     = push_req_s && full_s && !pop_s;
    load_s     = (width_q == '0) ? MEM'(1) : width_q;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (abort_s) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_s) wr_ptr_d = wr_ptr_q + QSZ'(1);
      else        wr_ptr_d = wr_ptr_q;
      if (pop_s)  rd_ptr_d = rd_ptr_q + QSZ'(1);
      else        rd_ptr_d = rd_ptr_q;
      level_d = level_q + (QSZ+1)'(push_s) - (QSZ+1)'(pop_s);
    end

    if (clr_s)                          fired_d = '0;
    else if (pop_s && (fired_q != '1))  fired_d = fired_q + MEM'(1);
    else                                fired_d = fired_q;
    if (clr_s)                           dropped_d = '0;
    else if (drop_s && (dropped_q != '1)) dropped_d = dropped_q + MEM'(1);
    else                                 dropped_d = dropped_q;

    state_d = state_q;
    cnt_d   = cnt_q;
    gate_d  = gate_q;
    if (abort_s) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      gate_d  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pop_s) begin
            state_d = S_PULSE;
            cnt_d   = load_s;
            gate_d  = 1'b1;
          end else begin
            gate_d  = 1'b0;
          end
        end
        S_PULSE: begin
          if (pop_s) begin
            cnt_d   = load_s;
            gate_d  = 1'b1;
          end else if (cnt_q <= MEM'(1)) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            gate_d  = 1'b0;
          end else begin
            cnt_d   = cnt_q - MEM'(1);
            gate_d  = 1'b1;
          end
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
          gate_d  = 1'b0;
        end
      endcase
    end
    dac_d  = gate_d ? amp_q : '0;
    busy_d = (level_d != '0) || gate_d;

    case (sys_addr[19:0])
      20'h00000: rd_s = 32'(delay_q);
      20'h00004: rd_s = 32'(width_q);
      20'h00008: rd_s = 32'(signed'(amp_q));
      20'h0000C: rd_s = {30'd0, 1'b0, en_q};
      20'h00010: rd_s = 32'(fired_q);
      20'h00014: rd_s = 32'(dropped_q);
      20'h00018: rd_s = 32'(level_q);
      default:   rd_s = 32'd0;
    endcase
  end

  // Timestamp, edge capture, bus registers, queue pointers and counters.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      ts_q      <= '0;
      trig_q    <= 1'b1;
      edge_q    <= 1'b0;
      stamp_q   <= '0;
      en_q      <= 1'b0;
      delay_q   <= '0;
      width_q   <= MEM'(1000);
      amp_q     <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      fired_q   <= '0;
      dropped_q <= '0;
      ack_q     <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      ts_q    <= ts_q + MEM'(1);
      trig_q  <= sort_trig_i;
      edge_q  <= sort_trig_i && !trig_q;
      stamp_q <= ts_q;
      en_q    <= en_d;
      if (sys_wen) begin
        case (sys_addr[19:0])
          20'h00000: delay_q <= MEM'(sys_wdata);
          20'h00004: width_q <= MEM'(sys_wdata);
          20'h00008: amp_q   <= sys_wdata[OWT-1:0];
          default:   ;
        endcase
      end
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      fired_q   <= fired_d;
      dropped_q <= dropped_d;
      ack_q     <= sys_wen || sys_ren;
      if (sys_ren) rdata_q <= rd_s;
    end
  end

  // Due-time storage; contents are meaningless while the level is zero.
  always_ff @(posedge adc_clk_i) begin
    if (push_s) q_mem[wr_ptr_q] <= stamp_q + delay_q;
  end

  // IDLE/PULSE sequencer with registered gate, amplitude and busy.
  always_ff @(posedge adc_clk_i) begin
    if (adc_rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      dac_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      dac_q   <= dac_d;
      busy_q  <= busy_d;
    end
  end

  assign gate_o    = gate_q;
  assign dac_o     = dac_q;
  assign busy_o    = busy_q;
  assign sys_rdata = rdata_q;
  assign sys_ack   = ack_q;
  assign sys_err   = 1'b0;

endmodule

// File: tb/tb_red_pitaya_sort_pulser.sv
// Directed bench for red_pitaya_sort_pulser; MEM is narrowed so the timestamp
// wrap can be reached from reset in a few thousand cycles.
module tb_red_pitaya_sort_pulser;
  localparam int QSZ = 3;
  localparam int MEM = 12;
  localparam int OWT = 14;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           trig = 1'b0;
  logic           gate, busy, sys_err, sys_ack;
  logic [OWT-1:0] dac;
  logic [31:0]    sys_addr = 32'd0, sys_wdata = 32'd0, sys_rdata;
  logic [3:0]     sys_sel = 4'hF;
  logic           sys_wen = 1'b0, sys_ren = 1'b0;

  int cyc = 0;
  int checks = 0;
  int failures = 0;

  red_pitaya_sort_pulser #(.QSZ(QSZ), .MEM(MEM), .OWT(OWT)) dut (
    .adc_clk_i(clk), .adc_rst_i(rst), .sort_trig_i(trig),
    .gate_o(gate), .dac_o(dac), .busy_o(busy),
    .sys_addr(sys_addr), .sys_wdata(sys_wdata), .sys_sel(sys_sel),
    .sys_wen(sys_wen), .sys_ren(sys_ren), .sys_rdata(sys_rdata),
    .sys_err(sys_err), .sys_ack(sys_ack)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
    sys_addr = a; sys_wdata = d; sys_wen = 1'b1;
    tick();
    sys_wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [31:0] a, output logic [31:0] d);
    sys_addr = a; sys_ren = 1'b1;
    tick();
    chk("rd_ack", {31'd0, sys_ack}, 32'd1);
    d = sys_rdata;
    sys_ren = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_rd(a, d);
    chk(tag, d, exp);
  endtask

  task automatic train(input int n, input int period, input int high);
    for (int i = 0; i < n; i++) begin
      trig = 1'b1;
      repeat (high) tick();
      trig = 1'b0;
      repeat (period - high) tick();
    end
  endtask

  // Observes gate/dac for span cycles; n0 is the cycle the first edge is sampled.
  task automatic scan(input string tag, input int n0, input int exp_rise, input int exp_len,
                      input int span, input logic [OWT-1:0] amp);
    int rise = -1;
    int len = 0;
    int rises = 0;
    int bad = 0;
    logic prev = 1'b0;
    for (int i = 0; i < span; i++) begin
      tick();
      if (gate) begin
        if (!prev) begin
          rises++;
          if (rise < 0) rise = cyc - n0;
        end
        len++;
        if (dac !== amp) bad++;
      end else if (dac !== '0) begin
        bad++;
      end
      prev = gate;
    end
    chk({tag, "_rise"}, rise, exp_rise);
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_nrise"}, rises, 32'd1);
    chk({tag, "_dacbad"}, bad, 32'd0);
    chk({tag, "_busy_end"}, {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_gate(input string tag);
    int n = 0;
    while (!gate && n < 300) begin
      tick();
      n++;
    end
    chk({tag, "_gate_seen"}, {31'd0, gate}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0;
    int rel;

    repeat (3) tick();
    chk("rst_gate", {31'd0, gate}, 32'd0);
    chk("rst_dac", 32'(dac), 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_ack", {31'd0, sys_ack}, 32'd0);
    chk("rst_err", {31'd0, sys_err}, 32'd0);
    chk("rst_rdata", sys_rdata, 32'd0);
    rst = 1'b0;
    rel = cyc;
    rd_chk("rst_delay", 32'h00, 32'd0);
    rd_chk("rst_width", 32'h04, 32'd1000);
    rd_chk("rst_amp", 32'h08, 32'd0);
    rd_chk("rst_ctrl", 32'h0C, 32'd0);
    rd_chk("rst_level", 32'h18, 32'd0);

    // Timestamp wrap: edge near 2^MEM-20, due time lands past the wrap.
    bus_wr(32'h00, 32'd40);
    bus_wr(32'h04, 32'd5);
    bus_wr(32'h08, 32'h0000_0AAA);
    bus_wr(32'h0C, 32'd1);
    while (cyc - rel < (1 << MEM) - 26) tick();
    n0 = cyc + 1;
    fork
      train(1, 4, 2);
      scan("wrap", n0, 42, 5, 60, 14'h0AAA);
    join
    rd_chk("wrap_fired", 32'h10, 32'd1);

    // Basic pulse: DELAY=100, WIDTH=10, AMP=0x1F00.
    bus_wr(32'h0C, 32'd3);
    bus_wr(32'h00, 32'd100);
    bus_wr(32'h04, 32'd10);
    bus_wr(32'h08, 32'h0000_1F00);
    n0 = cyc + 1;
    fork
      train(1, 4, 2);
      scan("basic", n0, 102, 10, 130, 14'h1F00);
    join
    rd_chk("basic_fired", 32'h10, 32'd1);

    // Zero delay, zero width: one-cycle gate two cycles after the edge.
    bus_wr(32'h00, 32'd0);
    bus_wr(32'h04, 32'd0);
    n0 = cyc + 1;
    fork
      train(1, 4, 2);
      scan("w0", n0, 2, 1, 12, 14'h1F00);
    join
    rd_chk("w0_fired", 32'h10, 32'd2);

    // Overflow: 10 edges within the delay, 8 queued, 2 dropped, retriggered gate.
    bus_wr(32'h0C, 32'd3);
    bus_wr(32'h00, 32'd50);
    bus_wr(32'h04, 32'd1000);
    bus_wr(32'h08, 32'h0000_0123);
    n0 = cyc + 1;
    fork
      train(10, 5, 2);
      scan("burst", n0, 52, 1035, 1100, 14'h0123);
      begin
        repeat (47) tick();
        rd_chk("burst_level", 32'h18, 32'd8);
        rd_chk("burst_dropped", 32'h14, 32'd2);
        chk("burst_busy", {31'd0, busy}, 32'd1);
      end
    join
    rd_chk("burst_fired", 32'h10, 32'd8);
    rd_chk("burst_level_end", 32'h18, 32'd0);

    // Mid-pulse clear with a second droplet still queued.
    bus_wr(32'h00, 32'd20);
    bus_wr(32'h04, 32'd50);
    bus_wr(32'h08, 32'h0000_0055);
    train(2, 5, 2);
    wait_gate("clr");
    repeat (2) tick();
    bus_wr(32'h0C, 32'd3);
    chk("clr_gate", {31'd0, gate}, 32'd0);
    chk("clr_dac", 32'(dac), 32'd0);
    rd_chk("clr_level", 32'h18, 32'd0);
    rd_chk("clr_fired", 32'h10, 32'd0);
    rd_chk("clr_dropped", 32'h14, 32'd0);
    rd_chk("clr_ctrl", 32'h0C, 32'd1);
    n0 = cyc + 1;
    fork
      train(1, 4, 2);
      scan("post_clr", n0, 22, 50, 90, 14'h0055);
    join
    rd_chk("post_clr_fired", 32'h10, 32'd1);

    // Bus behaviour: sign-extended AMP, unmapped read, read-only write ignored.
    bus_wr(32'h08, 32'hFFFF_2000);
    rd_chk("amp_sext", 32'h08, 32'hFFFF_E000);
    tick();
    chk("ack_drop", {31'd0, sys_ack}, 32'd0);
    rd_chk("unmapped", 32'h1C, 32'd0);
    chk("err", {31'd0, sys_err}, 32'd0);
    bus_wr(32'h10, 32'h55);
    rd_chk("ro_fired", 32'h10, 32'd1);

    // Live AMP change mid-pulse, then reset mid-pulse.
    bus_wr(32'h00, 32'd2);
    bus_wr(32'h04, 32'd40);
    bus_wr(32'h08, 32'h0000_0100);
    train(1, 4, 2);
    wait_gate("amp");
    bus_wr(32'h08, 32'h0000_0200);
    chk("amp_old", 32'(dac), 32'h100);
    tick();
    chk("amp_new", 32'(dac), 32'h200);
    rst = 1'b1;
    tick();
    chk("mrst_gate", {31'd0, gate}, 32'd0);
    chk("mrst_dac", 32'(dac), 32'd0);
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    rd_chk("mrst_width", 32'h04, 32'd1000);
    rd_chk("mrst_ctrl", 32'h0C, 32'd0);
    rd_chk("mrst_fired", 32'h10, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/red_pitaya_sort_pulser.md
Name: red_pitaya_sort_pulser

Overview:
Consumer end of the FADS sort trigger. Each rising edge of sort_trig_i is timestamped and queued. After a programmable travel delay from detector to sorting junction, the block emits a gate pulse of programmable width with a programmable signed amplitude, which drives the ASG or HV amplifier path. Up to 2^QSZ droplets can be in flight between detector and junction; all registers are reachable over the system bus.

Parameters:
QSZ, 3, log2 of pending-trigger queue depth (8 entries)
MEM, 32, width of timestamp, delay, width and counter registers
OWT, 14, width of the signed amplitude output

Ports:
adc_clk_i  in  1  ADC clock, sole clock
adc_rst_i  in  1  reset; one clock, reset is synchronous and active-high
sort_trig_i  in  1  sort request from the detector; rising edge = one droplet
gate_o  out  1  actuation gate
dac_o  out  OWT  signed amplitude while gate_o=1, else 0
busy_o  out  1  high when queue non-empty or gate_o=1
sys_addr  in  32  bus address
sys_wdata  in  32  bus write data
sys_sel  in  4  byte select (ignored; full-word writes)
sys_wen  in  1  bus write enable
sys_ren  in  1  bus read enable
sys_rdata  out  32  bus read data
sys_err  out  1  bus error, always 0
sys_ack  out  1  bus acknowledge

Behaviour:
- Reset: gate_o=0, dac_o=0, busy_o=0, sys_ack=0, sys_err=0, sys_rdata=0; queue empty; timestamp=0; counters=0; DELAY=0, WIDTH=1000, AMP=0, EN=0.
- Registers (sys_addr[19:0]): 0x00 DELAY rw; 0x04 WIDTH rw; 0x08 AMP rw, sign-extended on read; 0x0C CTRL: bit0 EN rw, bit1 CLR write-1 self-clearing, reads 0; 0x10 FIRED ro; 0x14 DROPPED ro; 0x18 LEVEL ro (queue occupancy, 0..2^QSZ); other addresses read 0 and ignore writes. Writes to ro addresses are ignored.
- Bus timing: sys_ack = sys_wen|sys_ren, registered, 1 cycle later. Write takes effect on the cycle after sys_wen.
- Timestamp: free-running MEM-bit counter that wraps modulo 2^MEM.
- Edge detect: sort_trig_i is registered once. An edge is detected in cycle N when the input is 1 at N and 0 at N-1.
- Push: in cycle N+1, if EN=1, enqueue due = ts(N) + DELAY, modulo 2^MEM. If the queue is full and there is no pop in the same cycle, drop the trigger and increment DROPPED. A simultaneous pop and push at full is accepted.
- Due test: head is due when the signed MEM-bit value (ts - head.due) >= 0. This is wrap-safe. DELAY must be < 2^(MEM-1); larger values give undefined timing.
- FSM IDLE/PULSE:
  - IDLE: when head is due, pop it, load the width counter with max(WIDTH,1), go to PULSE, and increment FIRED.
  - PULSE: gate_o=1 and dac_o=AMP. The counter decrements each cycle. When it reaches 1 and no new head is due, go to IDLE.
  - Head due while in PULSE: pop, reload the counter (retrigger extends the gate), increment FIRED.
- Latency: gate_o first high in cycle N+DELAY+2. Width is exactly max(WIDTH,1) cycles for an isolated trigger.
- AMP and WIDTH are sampled live: an AMP change mid-pulse appears on dac_o next cycle. WIDTH is only read at load.
- DELAY change affects only later pushes. Queued entries keep their due times. Non-monotonic due order is served in FIFO order; a later-due head blocks behind the earlier one.
- EN=0: triggers ignored, queue flushed, FSM forced to IDLE, gate_o/dac_o to 0 next cycle (aborts pulse). Counters hold.
- CLR: same flush/abort as EN=0, plus FIRED=DROPPED=0. EN is unchanged.
- Counters saturate at 2^MEM-1.
- adc_rst_i mid-pulse: all state returns to reset values next cycle. A trigger held high across reset release does not fire; its 0→1 history is lost.

Test Plan:
- EN=1, DELAY=100, WIDTH=10, AMP=0x1F00; trigger edge at cycle N -> gate_o high cycles N+102..N+111, dac_o=0x1F00 there, 0 elsewhere, FIRED=1.
- DELAY=0, WIDTH=0; single edge -> exactly 1-cycle gate at N+2.
- DELAY=50, WIDTH=1000; 10 edges 5 cycles apart -> 8 queued, DROPPED=2 (all 10 edges arrive within 50 cycles, before the first pop); the gate is one continuous pulse from retriggers; FIRED=8; LEVEL readback=8 before the first pop.
- Pre-load timestamp region near 2^32-20 (run from reset); DELAY=40; edge there -> gate fires exactly 42 cycles later across the wrap.
- Mid-pulse write CTRL=0x3 (EN=1, CLR) -> gate_o=0 next cycle, LEVEL=0, FIRED=DROPPED=0, EN stays 1; a subsequent edge fires normally.
- Bus: write 0x08=0xFFFF2000 -> read 0x08 returns 0xFFFFE000 with sys_ack one cycle after sys_ren; read 0x1C -> 0, sys_err=0.
